adc_capture_buffer: RTL and testbench
=====================================

ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of buffer depth in 16-bit words (DEPTH = 2**DEPTH_LOG2).
REQ-002 Parameter PRETRIG, default 64, words kept before trigger word; legal range 1..DEPTH-2.
REQ-003 adc_dco_clk  in  1  sole clock: BUFR'd ADC DCO; all logic on rising edge.
REQ-004 adc_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 adc_data_p  in  8  IDDR Q1 sample, rising-edge, earlier in time.
REQ-006 adc_data_n  in  8  IDDR Q2 sample, falling-edge, later in time.
REQ-007 arm  in  1  single-cycle pulse, starts a capture.
REQ-008 trig_level  in  8  unsigned level threshold.
REQ-009 trig_ext  in  1  forced trigger, level-sensitive.
REQ-010 rd_en  in  1  read-one-word strobe.
REQ-011 rd_data  out  16  captured word {n,p}.
REQ-012 rd_valid  out  1  rd_data valid this cycle.
REQ-013 busy  out  1  high in FILL, WAIT_TRIG, POST.
REQ-014 done  out  1  high in DONE.

Function
REQ-015 Word = {adc_data_n, adc_data_p}, registered once on input; the registered word is the write data.
REQ-016 States IDLE, FILL, WAIT_TRIG, POST, DONE; single-port-write/single-port-read RAM of DEPTH x 16.
REQ-017 IDLE: no writes; arm -> FILL, write pointer wp=0, fill counter=0.
REQ-018 FILL: write every cycle, wp increments mod DEPTH; after PRETRIG writes -> WAIT_TRIG; triggers ignored.
REQ-019 WAIT_TRIG: write every cycle, wp wraps; trigger = trig_ext high OR (prev registered p < trig_level AND current registered p >= trig_level); trigger word's address latched as ta -> POST.
REQ-020 Trigger comparison uses only p bytes of consecutive registered words; prev p cleared to 0 at FILL entry.
REQ-021 POST: write DEPTH-PRETRIG-1 further words after the trigger word, then -> DONE; buffer holds exactly DEPTH words ending at ta+DEPTH-PRETRIG-1.
REQ-022 DONE: no writes; read pointer rp initialised to (ta-PRETRIG) mod DEPTH on entry.
REQ-023 rd_en in DONE: RAM read at rp, rd_data/rd_valid the next cycle (latency 1), rp increments mod DEPTH.
REQ-024 After DEPTH reads -> IDLE; the last word's rd_valid still asserts in the cycle after the transition.
REQ-025 rd_en outside DONE ignored, rd_valid stays 0; rd_data holds last value.
REQ-026 arm in FILL/WAIT_TRIG/POST ignored; arm in DONE aborts readout and restarts as REQ-017; arm and rd_en same cycle in DONE: arm wins, no read issued.
REQ-027 Reading order: first word out = word PRETRIG before trigger; word at index PRETRIG = trigger word.

Reset
REQ-028 adc_reset_n low: state IDLE, wp/rp/ta/counters 0, prev p 0, busy=0, done=0, rd_valid=0, rd_data=0; RAM contents not cleared.
REQ-029 Reset mid-capture or mid-readout discards the capture; after release block waits in IDLE for arm.

Configuration
REQ-030 Macro ADC_CAPTURE_TESTPAT_EN defined: registered word replaced by internal 8-bit ramp r: p=r, n=r+1, r += 2 each cycle, r reset to 0 and cleared on arm; ADC inputs unused.
REQ-031 Macro undefined: ramp logic absent, word from ADC inputs per REQ-015.

Structure
REQ-032 Shared package adc_pkg: state enum type, ADC_BITS=8, WORD_BITS=16 constants.
REQ-033 One sub-module adc_capture_ram (inferred simple-dual-port BRAM, 1-cycle registered read); FSM, pointers, trigger in top.

Verification
REQ-034 DEPTH_LOG2=4, PRETRIG=4, TESTPAT on: arm, trig_ext at 10th cycle after arm -> DONE after 11 further writes; 16 reads return consecutive ramp words, word 4 equal to trigger word.
REQ-035 Level trigger: p sequence 0x10,0x20,0x7F,0x80 with trig_level=0x80 after FILL -> trigger on 0x80 word; 0x80->0x90 alone causes no trigger.
REQ-036 Wrap: hold trigger off 40 cycles (DEPTH=16) -> readout start address = (ta-4) mod 16, data continuous across address 15->0.
REQ-037 arm during POST ignored; arm during DONE after 3 reads -> busy=1 next cycle, done=0, rd_valid=0.
REQ-038 adc_reset_n low mid-POST -> all outputs 0 asynchronously; rd_en afterwards -> rd_valid stays 0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and widths for the ADC capture buffer.
package adc_pkg;

    localparam int unsigned ADC_BITS  = 8;
    localparam int unsigned WORD_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_e;

    // Captured word: falling-edge sample in the upper byte.
    typedef struct packed {
        logic [ADC_BITS-1:0] n;
        logic [ADC_BITS-1:0] p;
    } adc_word_t;

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module adc_capture_ram
    import adc_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WORD_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WORD_BITS-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [WORD_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_capture_buffer.sv
// Pre/post-trigger ADC capture buffer with ordered readout.
// Define ADC_CAPTURE_TESTPAT_EN to replace the ADC input with an internal ramp.
module adc_capture_buffer
    import adc_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned PRETRIG    = 64
) (
    input  logic                 adc_dco_clk,
    input  logic                 adc_reset_n,
    input  logic [ADC_BITS-1:0]  adc_data_p,
    input  logic [ADC_BITS-1:0]  adc_data_n,
    input  logic                 arm,
    input  logic [ADC_BITS-1:0]  trig_level,
    input  logic                 trig_ext,
    input  logic                 rd_en,
    output logic [WORD_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [AW-1:0] FILL_LAST = AW'(PRETRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 2);
    localparam logic [AW-1:0] READ_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);

    cap_state_e          state, state_d;
    adc_word_t           word_q;
    logic [AW-1:0]       wp, wp_d, rp, rp_d, ta, ta_d, cnt, cnt_d;
    logic [ADC_BITS-1:0] prev_p, prev_p_d;
    logic                we_c, re_c, start_c, trig_hit_c;

`ifdef ADC_CAPTURE_TESTPAT_EN
    logic [ADC_BITS-1:0] ramp;

    // Ramp source: p=r, n=r+1, advancing by two per cycle.
    always_ff @(posedge adc_dco_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            ramp   <= '0;
            word_q <= '0;
        end else begin
            word_q <= '{n: ramp + ADC_BITS'(1), p: ramp};
            ramp   <= arm ? '0 : ramp + ADC_BITS'(2);
        end
    end
`else
    always_ff @(posedge adc_dco_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            word_q <= '0;
        end else begin
            word_q <= '{n: adc_data_n, p: adc_data_p};
        end
    end
`endif

    assign start_c    = arm && ((state == ST_IDLE) || (state == ST_DONE));
    assign trig_hit_c = trig_ext || ((prev_p < trig_level) && (word_q.p >= trig_level));

    // Next-state, pointer and RAM-strobe logic.
    always_comb begin
        state_d  = state;
        wp_d     = wp;
        rp_d     = rp;
        ta_d     = ta;
        cnt_d    = cnt;
        prev_p_d = prev_p;
        we_c     = 1'b0;
        re_c     = 1'b0;
        if (start_c) begin
            state_d  = ST_FILL;
            wp_d     = '0;
            cnt_d    = '0;
            prev_p_d = '0;
        end else begin
            case (state)
                ST_FILL: begin
                    we_c     = 1'b1;
                    wp_d     = wp + AW'(1);
                    cnt_d    = cnt + AW'(1);
                    prev_p_d = word_q.p;
                    if (cnt == FILL_LAST) begin
                        state_d = ST_WAIT_TRIG;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_TRIG: begin
                    we_c     = 1'b1;
                    wp_d     = wp + AW'(1);
                    prev_p_d = word_q.p;
                    if (trig_hit_c) begin
                        ta_d    = wp;
                        cnt_d   = '0;
                        state_d = ST_POST;
                    end
                end
                ST_POST: begin
                    we_c  = 1'b1;
                    wp_d  = wp + AW'(1);
                    cnt_d = cnt + AW'(1);
                    if (cnt == POST_LAST) begin
                        state_d = ST_DONE;
                        rp_d    = ta - PRE_OFS;
                        cnt_d   = '0;
                    end
                end
                ST_DONE: begin
                    if (rd_en) begin
                        re_c  = 1'b1;
                        rp_d  = rp + AW'(1);
                        cnt_d = cnt + AW'(1);
                        if (cnt == READ_LAST) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_dco_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            state    <= ST_IDLE;
            wp       <= '0;
            rp       <= '0;
            ta       <= '0;
            cnt      <= '0;
            prev_p   <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            wp       <= wp_d;
            rp       <= rp_d;
            ta       <= ta_d;
            cnt      <= cnt_d;
            prev_p   <= prev_p_d;
            rd_valid <= re_c;
            busy     <= (state_d == ST_FILL) || (state_d == ST_WAIT_TRIG) ||
                        (state_d == ST_POST);
            done     <= (state_d == ST_DONE);
        end
    end

    adc_capture_ram #(
        .ADDR_BITS (AW)
    ) u_ram (
        .clk   (adc_dco_clk),
        .rst_n (adc_reset_n),
        .we    (we_c),
        .waddr (wp),
        .wdata (word_q),
        .re    (re_c),
        .raddr (rp),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer: capture-history reference model plus directed pins.
module tb_adc_capture_buffer;

    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  p_in = '0, n_in = '0, lvl = '0;
    logic        arm = 1'b0, trig_ext = 1'b0, rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid, busy, done;

    adc_capture_buffer #(.DEPTH_LOG2(DL2), .PRETRIG(PRE)) dut (
        .adc_dco_clk (clk),
        .adc_reset_n (rst_n),
        .adc_data_p  (p_in),
        .adc_data_n  (n_in),
        .arm         (arm),
        .trig_level  (lvl),
        .trig_ext    (trig_ext),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 capturing, 2 reading out.
    int          mode = 0, t_idx = -1, reads = 0;
    logic [15:0] hist[$];
    logic [7:0]  prev_p = '0;
    logic [15:0] regw = '0, m_data = '0;
    logic        m_valid = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mode = 0; t_idx = -1; reads = 0; prev_p = '0;
            regw = '0; m_data = '0; m_valid = 1'b0;
            hist.delete();
        end else begin
            logic [15:0] w, dn;
            logic        vn;
            int          k;
            vn = 1'b0;
            dn = m_data;
            if (arm && (mode == 0 || mode == 2)) begin
                mode = 1; hist.delete(); t_idx = -1; prev_p = '0;
            end else if (mode == 1) begin
                w = regw;
                k = hist.size();
                hist.push_back(w);
                if (t_idx < 0 && k >= PRE &&
                    (trig_ext || (prev_p < lvl && w[7:0] >= lvl)))
                    t_idx = k;
                prev_p = w[7:0];
                if (t_idx >= 0 && hist.size() == t_idx + DEPTH - PRE) begin
                    mode = 2; reads = 0;
                end
            end else if (mode == 2 && rd_en) begin
                dn = hist[t_idx - PRE + reads];
                vn = 1'b1;
                reads++;
                if (reads == DEPTH) mode = 0;
            end
            m_valid = vn;
            m_data  = dn;
            regw    = {n_in, p_in};
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en && rst_n) begin
            check("rd_valid", 32'(rd_valid), 32'(m_valid));
            check("rd_data",  32'(rd_data),  32'(m_data));
            check("busy",     32'(busy),     32'(mode == 1));
            check("done",     32'(done),     32'(mode == 2));
        end
    end

    logic [15:0] rb[$];
    initial forever begin
        @(negedge clk);
        if (rst_n && rd_valid) rb.push_back(rd_data);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int max, input string nm);
        int i = 0;
        while (!done && i < max) begin
            step();
            i++;
        end
        check(nm, 32'(done), 32'd1);
    endtask

    task automatic readout(input string nm);
        rb.delete();
        rd_en = 1'b1;
        repeat (DEPTH) step();
        rd_en = 1'b0;
        step();
        check(nm, 32'(rb.size()), 32'(DEPTH));
        check({nm, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    logic [7:0] c, trigp;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_outputs", {13'd0, rd_valid, busy, done, rd_data}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // Level trigger: 0x80->0x90 must not fire; 0x7F->0x80 must.
        lvl = 8'h80;
        p_in = 8'h80; n_in = ~p_in; arm = 1'b1; step(); arm = 1'b0;
        repeat (5) step();
        p_in = 8'h90; n_in = ~p_in;
        repeat (18) step();
        check("no_trig_above", {30'd0, busy, done}, 32'd2);
        begin
            logic [7:0] seq [4];
            seq = '{8'h10, 8'h20, 8'h7F, 8'h80};
            foreach (seq[i]) begin
                p_in = seq[i]; n_in = ~p_in; step();
            end
        end
        wait_done(40, "lvl_done");
        readout("lvl_rd");
        check("lvl_w0", 32'(rb[0]), 32'h6F90);
        check("lvl_w1", 32'(rb[1]), 32'hEF10);
        check("lvl_w3", 32'(rb[3]), 32'h807F);
        check("lvl_trig_word", 32'(rb[4]), 32'h7F80);

        // Wrap: trigger held off 40 cycles, ramp data on p.
        lvl = 8'h00; c = 8'd0; p_in = c; n_in = 8'hC3;
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 40; i++) begin c++; p_in = c; step(); end
        c++; p_in = c; trigp = c; trig_ext = 1'b1; step(); trig_ext = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin c++; p_in = c; step(); end
        check("wrap_done", 32'(done), 32'd1);
        readout("wrap_rd");
        check("wrap_trig_word", 32'(rb[4][7:0]), 32'(8'(trigp - 8'd1)));
        for (int i = 0; i + 1 < rb.size(); i++)
            check("wrap_contig", 32'(rb[i+1][7:0]), 32'(8'(rb[i][7:0] + 8'd1)));

        // arm in POST ignored; arm+rd_en in DONE after 3 reads restarts.
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 9; i++) begin p_in = 8'($urandom); n_in = 8'($urandom); step(); end
        trig_ext = 1'b1; step(); trig_ext = 1'b0;
        repeat (3) step();
        arm = 1'b1; step(); arm = 1'b0;
        check("arm_post_ignored", {30'd0, busy, done}, 32'd2);
        wait_done(20, "post_done");
        rd_en = 1'b1; repeat (3) step();
        arm = 1'b1; step(); arm = 1'b0; rd_en = 1'b0;
        check("arm_in_done", {29'd0, busy, done, rd_valid}, 32'd4);
        repeat (12) step();
        trig_ext = 1'b1; step(); trig_ext = 1'b0;
        wait_done(20, "rearm_done");
        readout("rearm_rd");

        // Reset mid-POST.
        arm = 1'b1; step(); arm = 1'b0;
        repeat (9) step();
        trig_ext = 1'b1; step(); trig_ext = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_post", {13'd0, rd_valid, busy, done, rd_data}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        rd_en = 1'b1;
        repeat (5) step();
        check("rd_after_rst", {30'd0, rd_valid, done}, 32'd0);
        rd_en = 1'b0;

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) lvl = 8'($urandom);
            p_in     = 8'($urandom);
            n_in     = 8'($urandom);
            trig_ext = ($urandom_range(0, 23) == 0);
            rd_en    = $urandom_range(0, 1) == 1;
            arm      = (!busy && !done) ? ($urandom_range(0, 3) == 0)
                                        : ($urandom_range(0, 59) == 0);
            step();
        end
        arm = 1'b0; rd_en = 1'b0; trig_ext = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
